// File: rtl/fp_mul_seq_if.sv
// Handshake and multiplier-unit bundle for fp_mul_seq.
// EXC_FLAGS_EN adds the flags_out signal to the bundle and both modports.
interface fp_mul_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                     in_vld;
  logic                     in_rdy;
  logic [EXP_W+MAN_W:0]     data1_in;
  logic [EXP_W+MAN_W:0]     data2_in;
  logic                     out_vld;
  logic                     out_rdy;
  logic [EXP_W+MAN_W:0]     data_out;
  logic [MAN_W:0]           mant_a_out;
  logic [MAN_W:0]           mant_b_out;
  logic                     mant_trig_out;
  logic [2*MAN_W+1:0]       mant_prod_in;
  logic                     mant_prod_vld;
`ifdef EXC_FLAGS_EN
  logic [3:0]               flags_out;

  modport slave (
    input  in_vld, data1_in, data2_in, out_rdy, mant_prod_in, mant_prod_vld,
    output in_rdy, out_vld, data_out, mant_a_out, mant_b_out, mant_trig_out, flags_out
  );
  modport master (
    output in_vld, data1_in, data2_in, out_rdy, mant_prod_in, mant_prod_vld,
    input  in_rdy, out_vld, data_out, mant_a_out, mant_b_out, mant_trig_out, flags_out
  );
`else
  modport slave (
    input  in_vld, data1_in, data2_in, out_rdy, mant_prod_in, mant_prod_vld,
    output in_rdy, out_vld, data_out, mant_a_out, mant_b_out, mant_trig_out
  );
  modport master (
    output in_vld, data1_in, data2_in, out_rdy, mant_prod_in, mant_prod_vld,
    input  in_rdy, out_vld, data_out, mant_a_out, mant_b_out, mant_trig_out
  );
`endif
endinterface

// File: rtl/fp_mul_seq.sv
// IEEE-754 multiply sequencer: specials handled locally, significand product offloaded, RNE rounding.
// Optional EXC_FLAGS_EN adds flags_out = {invalid, overflow, underflow, inexact}.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  fp_mul_seq_if.slave  bus,
  output logic [4:0]   state_dbg
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EXP_W+1:0] BIAS_E = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] EMAX_E = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ZERO_E = '0;

  // Handshakes: in_vld/in_rdy and out_vld/out_rdy transfer on a rising edge where both
  // are high; a raised valid keeps its data stable until that edge. mant_trig_out and
  // mant_prod_vld are single-cycle pulses with no back-pressure.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_PRE  = 5'b00010,
    S_WAIT = 5'b00100,
    S_NORM = 5'b01000,
    S_HOLD = 5'b10000
  } state_e;

  state_e                  state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d, res_q, res_d;
  logic [MAN_W:0]          ma_q, ma_d, mb_q, mb_d;
  logic [PW-1:0]           prod_q, prod_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic                    trig_q, trig_d, out_vld_q, out_vld_d;
`ifdef EXC_FLAGS_EN
  logic [3:0]              flags_q, flags_d;
`endif

  logic                    sa, sb, res_sign;
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        fa, fb;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                    spec_nan, special;
  logic [W-1:0]            spec_res;
  logic signed [EXP_W+1:0] e_pre;

  logic                    msb, guard, sticky, rnd_up, ovf, unf;
  logic [PW-1:0]           shifted;
  logic [MAN_W:0]          sig;
  logic [MAN_W+1:0]        sig_r;
  logic signed [EXP_W+1:0] e_n;
  logic [MAN_W-1:0]        frac_n;
  logic [W-1:0]            norm_res;

  // Subnormal operands count as zero here, which is what makes FTZ fall out of the zero rule.
  always_comb begin
    {sa, ea, fa} = a_q;
    {sb, eb, fb} = b_q;
    res_sign = sa ^ sb;
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (&ea) && (fa == '0);
    b_inf    = (&eb) && (fb == '0);
    a_nan    = (&ea) && (|fa);
    b_nan    = (&eb) && (|fb);
    spec_nan = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    special  = spec_nan || a_inf || b_inf || a_zero || b_zero;
    if (spec_nan)
      spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (a_inf || b_inf)
      spec_res = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      spec_res = {res_sign, {(EXP_W+MAN_W){1'b0}}};
    e_pre = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
  end

  // Align the product so the hidden bit sits at the top, then round the bits below the fraction.
  always_comb begin
    msb      = prod_q[PW-1];
    shifted  = msb ? prod_q : (prod_q << 1);
    sig      = shifted[PW-1 -: MAN_W+1];
    guard    = shifted[MAN_W];
    sticky   = |shifted[MAN_W-1:0];
    rnd_up   = guard & (sticky | sig[0]);
    sig_r    = {1'b0, sig} + {{(MAN_W+1){1'b0}}, rnd_up};
    e_n      = exp_q + $signed({{(EXP_W+1){1'b0}}, msb})
                     + $signed({{(EXP_W+1){1'b0}}, sig_r[MAN_W+1]});
    frac_n   = sig_r[MAN_W+1] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    ovf      = (e_n >= EMAX_E);
    unf      = (e_n <= ZERO_E);
    if (ovf)
      norm_res = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf)
      norm_res = {res_sign, {(EXP_W+MAN_W){1'b0}}};
    else
      norm_res = {res_sign, e_n[EXP_W-1:0], frac_n};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    prod_d    = prod_q;
    exp_d     = exp_q;
    trig_d    = 1'b0;
    out_vld_d = out_vld_q;
`ifdef EXC_FLAGS_EN
    flags_d   = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_vld) begin
          a_d     = bus.data1_in;
          b_d     = bus.data2_in;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (special) begin
          res_d     = spec_res;
          out_vld_d = 1'b1;
          state_d   = S_HOLD;
`ifdef EXC_FLAGS_EN
          flags_d   = {spec_nan, 3'b000};
`endif
        end else begin
          ma_d    = {1'b1, fa};
          mb_d    = {1'b1, fb};
          exp_d   = e_pre;
          trig_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mant_prod_vld) begin
          prod_d  = bus.mant_prod_in;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        res_d     = norm_res;
        out_vld_d = 1'b1;
        state_d   = S_HOLD;
`ifdef EXC_FLAGS_EN
        flags_d   = {1'b0, ovf, unf, guard | sticky | ovf | unf};
`endif
      end
      S_HOLD: begin
        if (bus.out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      prod_q    <= '0;
      exp_q     <= '0;
      trig_q    <= 1'b0;
      out_vld_q <= 1'b0;
`ifdef EXC_FLAGS_EN
      flags_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      prod_q    <= prod_d;
      exp_q     <= exp_d;
      trig_q    <= trig_d;
      out_vld_q <= out_vld_d;
`ifdef EXC_FLAGS_EN
      flags_q   <= flags_d;
`endif
    end
  end

  assign bus.in_rdy        = (state_q == S_IDLE);
  assign bus.out_vld       = out_vld_q;
  assign bus.data_out      = res_q;
  assign bus.mant_a_out    = ma_q;
  assign bus.mant_b_out    = mb_q;
  assign bus.mant_trig_out = trig_q;
`ifdef EXC_FLAGS_EN
  assign bus.flags_out     = flags_q;
`endif
  assign state_dbg         = state_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq with a latency-programmable significand multiplier model.
module tb_fp_mul_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;
  localparam int PW    = 48;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    bit           special;
    logic [W-1:0] res;
    logic [3:0]   flags;
  } vec_t;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [4:0] state_dbg;

  fp_mul_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_mul_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  int cyc      = 0;
  int trig_cnt = 0;
  int prod_cyc = 0;
  int mul_lat  = 1;
  int n_chk    = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (bus.mant_trig_out) trig_cnt <= trig_cnt + 1;
    if (bus.mant_prod_vld) prod_cyc <= cyc;
  end

  // ---------------- multiplier unit model ----------------
  initial begin
    logic [PW-1:0] p;
    int            l;
    bus.mant_prod_vld = 1'b0;
    bus.mant_prod_in  = '0;
    forever begin
      @(negedge sys_clk);
      if (bus.mant_trig_out) begin
        p = PW'(bus.mant_a_out) * PW'(bus.mant_b_out);
        l = mul_lat;
        repeat (l) @(posedge sys_clk);
        #1;
        bus.mant_prod_vld = 1'b1;
        bus.mant_prod_in  = p;
        @(posedge sys_clk);
        #1;
        bus.mant_prod_vld = 1'b0;
        bus.mant_prod_in  = '0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input vec_t v, input string tag, input bit hold5);
    int           acc_cyc, t0, vld_cyc;
    bit           got;
    logic [W-1:0] exp_v;
    logic [W-1:0] held;
    @(negedge sys_clk);
    mul_lat      = v.lat;
    bus.data1_in = v.a;
    bus.data2_in = v.b;
    bus.in_vld   = 1'b1;
    chk({tag, " in_rdy idle"}, 32'(bus.in_rdy), 32'd1);
    acc_cyc = cyc;
    t0      = trig_cnt;
    exp_q.push_back(v.res);
    @(negedge sys_clk);
    bus.in_vld   = 1'b0;
    bus.data1_in = $urandom();
    bus.data2_in = $urandom();
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bus.out_vld) got = 1'b1;
      else @(negedge sys_clk);
    end
    exp_v = exp_q.pop_front();
    if (!got) begin
      n_chk++;
      $display("FAIL %s timeout: out_vld not seen within 40 cycles", tag);
      return;
    end
    vld_cyc = cyc;
    chk({tag, " data_out"}, bus.data_out, exp_v);
    if (v.special) begin
      chk({tag, " special latency"}, 32'(vld_cyc - acc_cyc), 32'd2);
      chk({tag, " no trig"}, 32'(trig_cnt - t0), 32'd0);
    end else begin
      chk({tag, " latency after prod"}, 32'(vld_cyc - prod_cyc), 32'd2);
      chk({tag, " one trig"}, 32'(trig_cnt - t0), 32'd1);
      chk({tag, " mant_a_out"}, 32'(bus.mant_a_out), 32'({1'b1, v.a[MAN_W-1:0]}));
    end
`ifdef EXC_FLAGS_EN
    chk({tag, " flags"}, 32'(bus.flags_out), 32'(v.flags));
`endif
    if (hold5) begin
      held = bus.data_out;
      for (int k = 0; k < 5; k++) begin
        bus.in_vld   = 1'b1;
        bus.data1_in = 32'h3F800000;
        bus.data2_in = 32'h3F800000;
        @(negedge sys_clk);
        chk($sformatf("%s stall %0d data", tag, k), bus.data_out, held);
        chk($sformatf("%s stall %0d out_vld", tag, k), 32'(bus.out_vld), 32'd1);
        chk($sformatf("%s stall %0d in_rdy", tag, k), 32'(bus.in_rdy), 32'd0);
      end
      bus.in_vld = 1'b0;
    end
    bus.out_rdy = 1'b1;
    @(negedge sys_clk);
    bus.out_rdy = 1'b0;
    chk({tag, " out_vld drop"}, 32'(bus.out_vld), 32'd0);
    chk({tag, " in_rdy back"}, 32'(bus.in_rdy), 32'd1);
    if (hold5) begin
      repeat (3) @(negedge sys_clk);
      chk({tag, " extra in_vld ignored"}, 32'(state_dbg), 32'd1);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    bit seen;
    bus.in_vld   = 1'b0;
    bus.out_rdy  = 1'b0;
    bus.data1_in = '0;
    bus.data2_in = '0;

    //                 a             b             L  sp  result        {inv,ovf,unf,inx}
    vecs.push_back(vec_t'{32'h40000000, 32'h40400000, 3, 0, 32'h40C00000, 4'b0000});
    vecs.push_back(vec_t'{32'h3FC00000, 32'h3FC00000, 1, 0, 32'h40100000, 4'b0000});
    vecs.push_back(vec_t'{32'h3F800001, 32'h3F800001, 5, 0, 32'h3F800002, 4'b0001});
    vecs.push_back(vec_t'{32'h7F800000, 32'h00000000, 1, 1, 32'h7FC00000, 4'b1000});
    vecs.push_back(vec_t'{32'hFF800000, 32'h40000000, 1, 1, 32'hFF800000, 4'b0000});
    vecs.push_back(vec_t'{32'h7F000000, 32'hFF000000, 2, 0, 32'hFF800000, 4'b0101});
    vecs.push_back(vec_t'{32'h00800000, 32'h00800000, 4, 0, 32'h00000000, 4'b0011});
    vecs.push_back(vec_t'{32'h7FC00001, 32'h3F800000, 1, 1, 32'h7FC00000, 4'b1000});
    vecs.push_back(vec_t'{32'h80000001, 32'h3F800000, 1, 1, 32'h80000000, 4'b0000});
    vecs.push_back(vec_t'{32'hC0000000, 32'h40400000, 8, 0, 32'hC0C00000, 4'b0000});
    vecs.push_back(vec_t'{32'h3FFFFFFE, 32'h3F800001, 2, 0, 32'h40000000, 4'b0001});
    vecs.push_back(vec_t'{32'h3F800001, 32'h3FC00000, 3, 0, 32'h3FC00002, 4'b0001});
    vecs.push_back(vec_t'{32'h3F800003, 32'h3FC00000, 3, 0, 32'h3FC00004, 4'b0001});
    vecs.push_back(vec_t'{32'h7F000000, 32'h3F800000, 2, 0, 32'h7F000000, 4'b0000});
    vecs.push_back(vec_t'{32'h7F000000, 32'h40000000, 2, 0, 32'h7F800000, 4'b0101});
    vecs.push_back(vec_t'{32'h00800000, 32'h3F800000, 2, 0, 32'h00800000, 4'b0000});
    vecs.push_back(vec_t'{32'h00800000, 32'h3F000000, 2, 0, 32'h00000000, 4'b0011});
    vecs.push_back(vec_t'{32'hFF800000, 32'hFF800000, 1, 1, 32'h7F800000, 4'b0000});
    vecs.push_back(vec_t'{32'h7F800000, 32'h00000001, 1, 1, 32'h7FC00000, 4'b1000});
    vecs.push_back(vec_t'{32'h80000000, 32'h40000000, 1, 1, 32'h80000000, 4'b0000});

    repeat (2) @(negedge sys_clk);
    chk("reset in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("reset out_vld", 32'(bus.out_vld), 32'd0);
    chk("reset data_out", bus.data_out, 32'd0);
    chk("reset trig", 32'(bus.mant_trig_out), 32'd0);
    chk("reset mant_a", 32'(bus.mant_a_out), 32'd0);
    chk("reset state", 32'(state_dbg), 32'd1);
    sys_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i], $sformatf("v%0d", i), 1'b0);

    run_op(vecs[0], "stall", 1'b1);

    // Reset while WAIT, then let the stale product arrive.
    @(negedge sys_clk);
    mul_lat      = 6;
    bus.data1_in = 32'h40000000;
    bus.data2_in = 32'h40400000;
    bus.in_vld   = 1'b1;
    @(negedge sys_clk);
    bus.in_vld = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      if (bus.mant_trig_out) seen = 1'b1;
      else @(negedge sys_clk);
    end
    chk("rst trig seen", 32'(seen), 32'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("rst mid out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst mid in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("rst mid mant_a", 32'(bus.mant_a_out), 32'd0);
    chk("rst mid state", 32'(state_dbg), 32'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge sys_clk);
      if (bus.out_vld || state_dbg != 5'b00001) seen = 1'b1;
    end
    chk("late product ignored", 32'(seen), 32'd0);
    run_op(vecs[2], "post-reset", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
